mem_responder: RTL
==================

# mem_responder

Synthesizable memory-side responder for the valid/ready memory protocol driven by the testbench BFM. It accepts one read or write request at a time and inserts a parameterized number of wait states. It completes each request with a one-cycle `ready` pulse, returning `rdata` for reads. It sits at the far end of `mem_interface` as the DUT the BFM and monitor talk to, and it flags out-of-range addresses.

## Interface
- `WIDTH`, 16, data width of `wdata`/`rdata`.
- `ADDR_WIDTH`, 5, address width.
- `DEPTH`, 24, number of implemented words, 1..2**ADDR_WIDTH; addresses >= DEPTH are out of range.
- `LAT`, 2, wait states between acceptance and response, 0..15.

Ports:
- `clk` input 1 — single clock; all logic on posedge.
- `rst` input 1 — synchronous, active-high reset.
- `valid` input 1 — request present; master holds it until it samples `ready`=1.
- `wr_rd` input 1 — 1 = write, 0 = read; qualified by `valid`.
- `addr` input ADDR_WIDTH — word address.
- `wdata` input WIDTH — write data.
- `ready` output 1 — one-cycle completion pulse, registered.
- `rdata` output WIDTH — read data, registered, valid while `ready`=1 for reads.
- `err` output 1 — high with `ready` when the completed request was out of range.

## Operation
- Storage: DEPTH × WIDTH register array. All words are cleared to 0 on reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when `valid`=1, capture `wr_rd`, `addr` and `wdata` into request registers. Go to RESP if LAT=0; otherwise go to WAIT with `cnt`=LAT-1.
  - WAIT: if `cnt`=0, go to RESP; else decrement `cnt`. Input changes are ignored; the captured request is used.
  - RESP: always return to IDLE. `valid` is ignored in this state, because the master's stale `valid` is still visible on this edge.
- Commit happens on the edge that enters RESP, using the captured request.
  - In-range write: mem[addr] ← wdata; `rdata` is unchanged; `err`=0.
  - In-range read: `rdata` ← mem[addr]; `err`=0.
  - Out-of-range request (addr >= DEPTH): the write is dropped, `rdata` ← 0, `err`=1.
- `ready` = (state==RESP). `err` is 0 whenever `ready` is 0.
- `rdata` holds its value between read responses.
- `valid` dropping before `ready` is a master protocol violation. The responder still completes the captured request.
- Reset outputs: `ready`=0, `err`=0, `rdata`=0, state=IDLE, `cnt`=0.
- Reset mid-transaction aborts the request. No write is committed unless the RESP-entry edge has already occurred.

## Timing
- Request sampled by the acceptance edge t (state IDLE, `valid`=1) → `ready` high for exactly the cycle from edge t+LAT to edge t+LAT+1.
- The master samples `ready` at edge t+LAT+1 and deasserts `valid` afterwards.
- The earliest next acceptance is edge t+LAT+2, which gives back-to-back throughput of one request per LAT+2 cycles.
- A master holding `valid` high continuously gets its next request accepted at t+LAT+2 with no idle cycle.
- Read-after-write to the same address returns the new data, because the write commits before the next acceptance.
- `cnt` is 4 bits wide. LAT=0 bypasses WAIT entirely.
- An `rst` high at any edge overrides all transitions on that edge.

## Test plan
- Reset, then check outputs for 3 cycles → `ready`=0, `err`=0, `rdata`=0; a read of addr 0 returns 0x0000.
- Write 0xA5A5 to addr 3 (accepted at edge t) → `ready` high exactly in cycle t+2..t+3 with LAT=2, `err`=0; a following read of addr 3 returns 0xA5A5 with `ready` at t'+2.
- Back-to-back with `valid` held high: write 0x1234@7, read @7, write 0xFFFF@23 → acceptances 4 cycles apart; the read returns 0x1234; mem[23]=0xFFFF.
- Out of range: write 0xBEEF to addr 24, then read addr 24 → both responses have `err`=1 and `rdata`=0; then read addr 23 → `err`=0, and mem[0..23] is otherwise unchanged.
- Master drops `valid` and changes `addr` from 5 to 9 during WAIT → the response still completes for addr 5; the next request is accepted no earlier than t+4.
- Assert `rst` during WAIT of a write of 0x5555 to addr 2 → `ready` never pulses; after reset, a read of addr 2 returns 0x0000.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one valid/ready request at a time, waits LAT
// cycles, then pulses ready for one cycle with read data or an out-of-range error.
module mem_responder #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 24,
  parameter int LAT        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err
);

  // Handshake: the master raises valid with wr_rd/addr/wdata and holds it until
  // it samples ready=1; ready is a single-cycle registered pulse per request, and
  // valid is ignored outside IDLE (a stale valid during RESP never re-accepts).
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0]            CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    req_wr_q, req_wr_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [WIDTH-1:0]        req_wdata_q, req_wdata_d;
  logic [WIDTH-1:0]        rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];

  logic                    enter_resp;
  logic                    c_wr;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [WIDTH-1:0]        c_wdata;
  logic                    in_range;

  // With LAT=0 the commit edge is the acceptance edge, so the live inputs are
  // used; otherwise the captured request is.
  always_comb begin
    c_wr     = (state_q == S_IDLE) ? wr_rd : req_wr_q;
    c_addr   = (state_q == S_IDLE) ? addr  : req_addr_q;
    c_wdata  = (state_q == S_IDLE) ? wdata : req_wdata_q;
    in_range = ({1'b0, c_addr} < DEPTH_W);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    mem_d       = mem_q;
    enter_resp  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          req_wr_d    = wr_rd;
          req_addr_d  = addr;
          req_wdata_d = wdata;
          if (LAT == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      if (!in_range) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else if (c_wr) begin
        mem_d[c_addr] = c_wdata;
      end else begin
        rdata_d = mem_q[c_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_q       <= mem_d;
    end
  end

  assign ready = (state_q == S_RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
